// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential Booth multiply / multiply-accumulate unit.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NONE = 2'd0,
    BOOTH_ADD  = 2'd1,
    BOOTH_SUB  = 2'd2
  } booth_op_t;

  // Pair is {current multiplier bit, previous multiplier bit}.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NONE;
    endcase
  endfunction

  // Bits needed for a counter that must reach the value 'steps'.
  function automatic int cnt_width(input int steps);
    return (steps < 2) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/seq_booth_mac_if.sv
// Operand and result channels of seq_booth_mac.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
// the sender holds valid and its payload steady until that edge, ready never waits on valid.
interface seq_booth_mac_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 mode;
  logic                 acc_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic                 overflow;

  modport master (
    output in_valid, a, b, mode, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, overflow
  );

  modport slave (
    input  in_valid, a, b, mode, acc_clr, out_ready,
    output in_ready, out_valid, out_data, overflow
  );
endinterface

// File: rtl/seq_booth_mac_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the upper
// half of the partial product, then an arithmetic right shift of the whole register.
module booth_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH:0] pp,
  input  logic [WIDTH-1:0] mcand,
  input  logic [1:0]       pair,
  output logic [2*WIDTH:0] pp_next
);

  logic [WIDTH:0] hi;
  logic [WIDTH:0] mc_ext;
  logic [WIDTH:0] hi_sum;

  // Upper half is one bit wider than the operand so that subtracting the most
  // negative multiplicand cannot overflow.
  always_comb begin
    hi     = pp[2*WIDTH:WIDTH];
    mc_ext = {mcand[WIDTH-1], mcand};
    hi_sum = hi;
    case (booth_decode(pair))
      BOOTH_ADD: hi_sum = hi + mc_ext;
      BOOTH_SUB: hi_sum = hi - mc_ext;
      default:   hi_sum = hi;
    endcase
    pp_next = {hi_sum[WIDTH], hi_sum, pp[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_booth_mac.sv
// Sequential signed multiplier / MAC: one Booth step per cycle, a finalize cycle that
// accumulates (wrap or clamp), then the result is held until the consumer takes it.
module seq_booth_mac
  import seq_mul_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_booth_mac_if.slave       bus,
  output state_t               dbg_state,
  output logic [ACC_WIDTH-1:0] dbg_acc
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_booth_mac: WIDTH must be at least 2");
  end
  if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc
    $error("seq_booth_mac: ACC_WIDTH must be at least 2*WIDTH");
  end

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH:0]       pp;
  logic [2*WIDTH:0]       pp_next;
  logic                   q_m1;
  logic [WIDTH-1:0]       mcand;
  logic                   mode_r;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   out_data_r;
  logic                   ovf_r;

  logic signed [2*WIDTH:0]  pp_s;
  logic signed [ACC_WIDTH:0] acc_ext, prod_ext, sum;
  logic [ACC_WIDTH-1:0]     result;
  logic                     result_ovf;
  logic                     last_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .pp      (pp),
    .mcand   (mcand),
    .pair    ({pp[0], q_m1}),
    .pp_next (pp_next)
  );

  assign last_step = (cnt == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.in_valid)  state_next = ST_BUSY;
      ST_BUSY: if (last_step)     state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Sum is formed one bit wider than the accumulator so overflow is visible before clamping.
  always_comb begin
    pp_s       = $signed(pp);
    prod_ext   = (ACC_WIDTH+1)'(pp_s);
    acc_ext    = {acc[ACC_WIDTH-1], acc};
    sum        = acc_ext + prod_ext;
    result     = prod_ext[ACC_WIDTH-1:0];
    result_ovf = 1'b0;
    if (mode_r) begin
      result = sum[ACC_WIDTH-1:0];
      if (SATURATE && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
        result_ovf = 1'b1;
        result     = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      pp         <= '0;
      q_m1       <= 1'b0;
      mcand      <= '0;
      mode_r     <= 1'b0;
      acc        <= '0;
      out_data_r <= '0;
      ovf_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.a;
            pp     <= {{(WIDTH+1){1'b0}}, bus.b};
            q_m1   <= 1'b0;
            mode_r <= bus.mode;
            cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (last_step) begin
            out_data_r <= result;
            ovf_r      <= result_ovf;
            if (mode_r) acc <= result;
          end else begin
            pp   <= pp_next;
            q_m1 <= pp[0];
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
      // A clear on the finalize edge wins over the accumulate write.
      if (bus.acc_clr) acc <= '0;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_data  = out_data_r;
  assign bus.overflow  = ovf_r;
  assign dbg_state     = state;
  assign dbg_acc       = acc;

endmodule

// File: tb/tb_seq_booth_mac.sv
// Bench for seq_booth_mac: three instances (24-bit wrap, 16-bit saturate, 16-bit wrap)
// share one stimulus stream and are scored against an arithmetic model of the MAC.
module tb_seq_booth_mac;
  import seq_mul_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_booth_mac_if #(.WIDTH(W), .ACC_WIDTH(24)) m_if ();
  seq_booth_mac_if #(.WIDTH(W), .ACC_WIDTH(16)) s_if ();
  seq_booth_mac_if #(.WIDTH(W), .ACC_WIDTH(16)) w_if ();

  assign s_if.in_valid  = m_if.in_valid;
  assign s_if.a         = m_if.a;
  assign s_if.b         = m_if.b;
  assign s_if.mode      = m_if.mode;
  assign s_if.acc_clr   = m_if.acc_clr;
  assign s_if.out_ready = m_if.out_ready;
  assign w_if.in_valid  = m_if.in_valid;
  assign w_if.a         = m_if.a;
  assign w_if.b         = m_if.b;
  assign w_if.mode      = m_if.mode;
  assign w_if.acc_clr   = m_if.acc_clr;
  assign w_if.out_ready = m_if.out_ready;

  state_t      st_m, st_s, st_w;
  logic [23:0] acc_m;
  logic [15:0] acc_s, acc_w;

  seq_booth_mac #(.WIDTH(W), .ACC_WIDTH(24), .SATURATE(1'b0)) dut_m (
    .clk(clk), .rst(rst), .bus(m_if.slave), .dbg_state(st_m), .dbg_acc(acc_m));
  seq_booth_mac #(.WIDTH(W), .ACC_WIDTH(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(s_if.slave), .dbg_state(st_s), .dbg_acc(acc_s));
  seq_booth_mac #(.WIDTH(W), .ACC_WIDTH(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .bus(w_if.slave), .dbg_state(st_w), .dbg_acc(acc_w));

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  longint macc_m = 0, macc_s = 0, macc_w = 0;
  logic [23:0] exp_m_q[$];
  logic [15:0] exp_s_q[$];
  logic [15:0] exp_w_q[$];
  logic        ovf_s_q[$];
  int          acc_cyc_q[$];
  int          issued = 0;
  int          hs_cnt = 0;

  function automatic longint wrap_to(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint clamp_to(input longint v, input int w, output bit ovf);
    longint hi, lo;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -(longint'(1) << (w - 1));
    ovf = 1'b0;
    if (v > hi) begin ovf = 1'b1; return hi; end
    if (v < lo) begin ovf = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_issue(input int ta, input int tb_v, input bit tm, input bit clr_after);
    longint p, rm, rs, rw;
    bit ov;
    p  = longint'(ta) * longint'(tb_v);
    ov = 1'b0;
    if (!tm) begin
      rm = p; rs = p; rw = p;
    end else begin
      macc_m = wrap_to(macc_m + p, 24);
      macc_w = wrap_to(macc_w + p, 16);
      macc_s = clamp_to(macc_s + p, 16, ov);
      rm = macc_m; rs = macc_s; rw = macc_w;
    end
    exp_m_q.push_back(rm[23:0]);
    exp_s_q.push_back(rs[15:0]);
    exp_w_q.push_back(rw[15:0]);
    ovf_s_q.push_back(ov);
    if (clr_after) begin macc_m = 0; macc_s = 0; macc_w = 0; end
  endtask

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;

  always @(posedge clk) begin
    #2;
    m_if.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic do_op(input int ta, input int tb_v, input bit tm, input bit clr_after);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    m_if.a        = 8'(ta);
    m_if.b        = 8'(tb_v);
    m_if.mode     = tm;
    m_if.in_valid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = m_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    m_if.in_valid = 1'b0;
    if (!ok) note_fail("accept_timeout");
    else begin
      acc_cyc_q.push_back(cyc);
      model_issue(ta, tb_v, tm, clr_after);
      issued++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (hs_cnt != issued && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (hs_cnt != issued) note_fail("drain_timeout");
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!m_if.out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!m_if.out_valid) note_fail("out_valid_timeout");
  endtask

  task automatic pulse_clr();
    m_if.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    m_if.acc_clr = 1'b0;
    macc_m = 0; macc_s = 0; macc_w = 0;
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit     prev_valid = 1'b0;
  bit     prev_ready = 1'b0;
  longint prev_m = 0, prev_s = 0;
  longint last_m = 0, last_s = 0, last_w = 0;
  longint last_ovf_s = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (m_if.out_valid) begin
        check("in_ready_low_in_done", m_if.in_ready, 0);
        check("lockstep_sat16", s_if.out_valid, 1);
        check("lockstep_wrap16", w_if.out_valid, 1);
        if (!prev_valid) begin
          if (acc_cyc_q.size() == 0) note_fail("unexpected_out_valid");
          else check("latency", cyc - acc_cyc_q.pop_front(), W + 1);
        end
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", m_if.out_valid, 1);
        check("hold_data24", longint'($signed(m_if.out_data)), prev_m);
        check("hold_data_sat16", longint'($signed(s_if.out_data)), prev_s);
      end
      if (m_if.out_valid && m_if.out_ready) begin
        if (exp_m_q.size() == 0) note_fail("result_without_request");
        else begin
          last_m     = longint'($signed(m_if.out_data));
          last_s     = longint'($signed(s_if.out_data));
          last_w     = longint'($signed(w_if.out_data));
          last_ovf_s = longint'(s_if.overflow);
          check("data_acc24", last_m, longint'($signed(exp_m_q.pop_front())));
          check("data_sat16", last_s, longint'($signed(exp_s_q.pop_front())));
          check("data_wrap16", last_w, longint'($signed(exp_w_q.pop_front())));
          check("ovf_sat16", last_ovf_s, longint'(ovf_s_q.pop_front()));
          check("ovf_acc24", m_if.overflow, 0);
          check("ovf_wrap16", w_if.overflow, 0);
          hs_cnt++;
        end
      end
      prev_valid = m_if.out_valid;
      prev_ready = m_if.out_ready;
      prev_m     = longint'($signed(m_if.out_data));
      prev_s     = longint'($signed(s_if.out_data));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_if.in_valid = 1'b0;
    m_if.a        = '0;
    m_if.b        = '0;
    m_if.mode     = 1'b0;
    m_if.acc_clr  = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", m_if.in_ready, 0);
    check("rst_out_valid", m_if.out_valid, 0);
    check("rst_out_data", m_if.out_data, 0);
    check("rst_overflow", s_if.overflow, 0);
    check("rst_acc", acc_m, 0);
    check("rst_state", longint'(st_m), longint'(ST_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", m_if.in_ready, 1);
    @(posedge clk);
    #1;

    // multiply-only and operand corners
    do_op(99, -50, 1'b0, 1'b0);    wait_idle(); check("mul_99_m50", last_m, -4950);
    do_op(-128, -128, 1'b0, 1'b0); wait_idle(); check("mul_min_min", last_m, 16384);
    do_op(-128, 127, 1'b0, 1'b0);  wait_idle(); check("mul_min_max", last_m, -16256);
    do_op(0, -1, 1'b0, 1'b0);      wait_idle(); check("mul_0_m1", last_m, 0);

    // accumulate sequence
    pulse_clr();
    do_op(99, -50, 1'b1, 1'b0);  wait_idle(); check("mac_first", last_m, -4950);
    do_op(72, -127, 1'b1, 1'b0); wait_idle(); check("mac_second", last_m, -14094);
    pulse_clr();
    do_op(-43, 9, 1'b1, 1'b0);   wait_idle(); check("mac_after_clr", last_m, -387);

    // saturation versus wrap at 16 bits
    pulse_clr();
    do_op(-128, -128, 1'b1, 1'b0); wait_idle();
    check("sat_first", last_s, 16384);
    do_op(-128, -128, 1'b1, 1'b0); wait_idle();
    check("sat_clamped", last_s, 32767);
    check("sat_ovf_flag", last_ovf_s, 1);
    check("wrap16_value", last_w, -32768);
    check("acc24_value", last_m, 32768);

    // clear on the finalize edge: result uses old acc, acc ends at zero
    pulse_clr();
    do_op(10, 10, 1'b1, 1'b0); wait_idle();
    do_op(3, 4, 1'b1, 1'b1);
    repeat (W) @(posedge clk);
    #1 m_if.acc_clr = 1'b1;
    @(posedge clk);
    #1 m_if.acc_clr = 1'b0;
    wait_idle(); check("clr_at_done_result", last_m, 112);
    do_op(5, 5, 1'b1, 1'b0); wait_idle(); check("clr_at_done_acc", last_m, 25);

    // clear while a result is held
    rdy_force = 1'b0;
    do_op(7, -3, 1'b1, 1'b1);
    wait_out_valid();
    pulse_clr();
    repeat (3) @(posedge clk);
    #1 rdy_force = 1'b1;
    wait_idle(); check("clr_in_done_held", last_m, 4);
    do_op(2, 3, 1'b1, 1'b0); wait_idle(); check("clr_in_done_acc", last_m, 6);

    // backpressure: a second operand pair waits for the handshake
    rdy_force = 1'b0;
    do_op(-77, 55, 1'b0, 1'b0);
    wait_out_valid();
    m_if.a = 8'(12); m_if.b = 8'(-11); m_if.mode = 1'b0; m_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", m_if.in_ready, 0);
      check("bp_out_valid", m_if.out_valid, 1);
    end
    @(posedge clk);
    #1 rdy_force = 1'b1;
    do_op(12, -11, 1'b0, 1'b0); wait_idle();
    check("bp_second_result", last_m, -132);

    // reset in the middle of BUSY
    do_op(50, 50, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    void'(exp_m_q.pop_back());
    void'(exp_s_q.pop_back());
    void'(exp_w_q.pop_back());
    void'(ovf_s_q.pop_back());
    void'(acc_cyc_q.pop_back());
    issued--;
    @(negedge clk);
    check("midrst_in_ready", m_if.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    macc_m = 0; macc_s = 0; macc_w = 0;
    @(negedge clk);
    check("midrst_ready_after", m_if.in_ready, 1);
    check("midrst_acc24", acc_m, 0);
    check("midrst_acc_sat16", acc_s, 0);
    check("midrst_acc_wrap16", acc_w, 0);
    check("midrst_state_sat", longint'(st_s), longint'(ST_IDLE));
    check("midrst_state_wrap", longint'(st_w), longint'(ST_IDLE));
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("midrst_no_out_valid", m_if.out_valid, 0);
    end
    @(posedge clk);
    #1;
    do_op(88, -66, 1'b0, 1'b0); wait_idle(); check("after_rst_mul", last_m, -5808);
    do_op(1, 1, 1'b1, 1'b0);    wait_idle(); check("after_rst_acc", last_m, 1);

    // randomized traffic with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        pulse_clr();
      end
      do_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
            1'($urandom_range(0, 1)), 1'b0);
    end
    wait_idle();
    rdy_rand = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    note_fail("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
